// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Parametrised hazard unit. Tracks in-flight register writers
//               for DEPTH stages past ID, produces per-operand forward
//               selects and a single stall for the ID-stage instruction,
//               plus a saturating stall-cycle counter.
//               Optional mult/div busy interlock: HAZARD_HILO_BUSY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREAD      = 2,
    parameter int DEPTH      = 4,
    parameter int AW         = 5,
    parameter int LOAD_READY = 2,
    parameter int BJ_MIN     = 1,
    parameter int MD_LAT     = 32,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [NREAD*AW-1:0]   id_src,
    input  logic                  id_bj,
    input  logic                  id_rfwr,
    input  logic [AW-1:0]         id_rd,
    input  logic                  id_late,
    input  logic                  pipe_adv,
    input  logic                  mem_stall,
    input  logic                  flush,
    input  logic                  md_start,
    input  logic                  id_md_use,
    output logic [NREAD*SELW-1:0] fwd_sel,
    output logic                  hazard_stall,
    output logic                  md_busy,
    output logic [31:0]           stall_cnt
);

    // Shadow tracker: entry 0 is EX, higher indices are older instructions.
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_late;
    logic [AW-1:0]    r_rd [DEPTH];

    logic             w_hilo_stall;
    logic [NREAD-1:0] w_op_stall;
    logic             w_insert;
    logic [31:0]      r_stall_cnt;

    // A stalled ID instruction must not enter the tracker; a bubble goes in instead.
    assign hazard_stall = id_valid & ((|w_op_stall) | w_hilo_stall);
    assign w_insert     = id_valid & id_rfwr & (id_rd != '0) & ~hazard_stall;
    assign stall_cnt    = r_stall_cnt;

    // Tracker update: flush clears, cache stall freezes, advance shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_late <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (flush) begin
            r_v <= '0;
        end else if (!mem_stall && pipe_adv) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_v[k]    <= r_v[k-1];
                r_late[k] <= r_late[k-1];
                r_rd[k]   <= r_rd[k-1];
            end
            r_v[0]    <= w_insert;
            r_late[0] <= id_late;
            r_rd[0]   <= id_rd;
        end
    end

    // Per-operand youngest-match search and readiness evaluation.
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_op
        logic [AW-1:0]   w_src;
        logic            w_hit;
        logic            w_rdy;
        logic [SELW-1:0] w_idx;

        assign w_src = id_src[gi*AW +: AW];

        // Scan oldest to youngest so the youngest matching entry is kept last.
        always_comb begin
            w_hit = 1'b0;
            w_rdy = 1'b0;
            w_idx = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (r_v[k] && (r_rd[k] == w_src) && (w_src != '0)) begin
                    w_hit = 1'b1;
                    w_idx = SELW'(k);
                    w_rdy = (!r_late[k] || (k >= LOAD_READY)) &&
                            (!id_bj     || (k >= BJ_MIN));
                end
            end
        end

        assign fwd_sel[gi*SELW +: SELW] = (id_valid && w_hit && w_rdy) ?
                                          (w_idx + SELW'(1)) : '0;
        assign w_op_stall[gi] = w_hit & ~w_rdy;
    end

`ifdef HAZARD_HILO_BUSY_EN
    localparam int c_MD_W = $clog2(MD_LAT + 1);

    logic [c_MD_W-1:0] r_md_cnt;

    // Mult/div countdown; unaffected by flush so an issued operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_cnt <= '0;
        end else if (!mem_stall) begin
            if (md_start) begin
                r_md_cnt <= c_MD_W'(MD_LAT);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - c_MD_W'(1);
            end
        end
    end

    assign md_busy      = (r_md_cnt != '0);
    assign w_hilo_stall = id_md_use & md_busy;
`else
    logic w_unused_md;

    assign md_busy      = 1'b0;
    assign w_hilo_stall = 1'b0;
    assign w_unused_md  = md_start ^ id_md_use ^ (MD_LAT == 0);
`endif

    // Saturating count of cycles spent in hazard stall; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (hazard_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard: directed pipeline
//               scenarios with literal expectations plus randomized traffic
//               compared every cycle against a behavioural model.
//               Exercises the mult/div interlock when HAZARD_HILO_BUSY_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NREAD      = 2;
    localparam int DEPTH      = 4;
    localparam int AW         = 5;
    localparam int LOAD_READY = 2;
    localparam int BJ_MIN     = 1;
    localparam int SELW       = 3;
`ifdef HAZARD_HILO_BUSY_EN
    localparam int MD_LAT     = 4;
`else
    localparam int MD_LAT     = 32;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  id_valid;
    logic [NREAD*AW-1:0]   id_src;
    logic                  id_bj;
    logic                  id_rfwr;
    logic [AW-1:0]         id_rd;
    logic                  id_late;
    logic                  pipe_adv;
    logic                  mem_stall;
    logic                  flush;
    logic                  md_start;
    logic                  id_md_use;
    logic [NREAD*SELW-1:0] fwd_sel;
    logic                  hazard_stall;
    logic                  md_busy;
    logic [31:0]           stall_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(
        .NREAD(NREAD), .DEPTH(DEPTH), .AW(AW), .LOAD_READY(LOAD_READY),
        .BJ_MIN(BJ_MIN), .MD_LAT(MD_LAT), .SELW(SELW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_bj(id_bj), .id_rfwr(id_rfwr), .id_rd(id_rd), .id_late(id_late),
        .pipe_adv(pipe_adv), .mem_stall(mem_stall), .flush(flush),
        .md_start(md_start), .id_md_use(id_md_use), .fwd_sel(fwd_sel),
        .hazard_stall(hazard_stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: list of in-flight writers, index 0 = youngest.
    bit            m_v    [DEPTH];
    logic [AW-1:0] m_rd   [DEPTH];
    bit            m_late [DEPTH];
    int            m_md;
    logic [31:0]   m_cnt;
    int            exp_sel [NREAD];
    bit            exp_stall;

    function automatic void model_eval();
        bit any_block;
        any_block = 0;
        for (int i = 0; i < NREAD; i++) begin
            logic [AW-1:0] src;
            int  hit_k;
            bit  ready;
            src   = id_src[i*AW +: AW];
            hit_k = -1;
            for (int k = 0; k < DEPTH; k++)
                if (hit_k < 0 && m_v[k] && m_rd[k] == src && src != 0) hit_k = k;
            exp_sel[i] = 0;
            if (hit_k >= 0) begin
                ready = (!m_late[hit_k] || hit_k >= LOAD_READY) && (!id_bj || hit_k >= BJ_MIN);
                if (ready && id_valid) exp_sel[i] = hit_k + 1;
                if (!ready) any_block = 1;
            end
        end
        exp_stall = id_valid && (any_block || (id_md_use && m_md != 0));
    endfunction

    function automatic void model_update();
        model_eval();
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) m_v[k] = 0;
            m_md  = 0;
            m_cnt = 0;
        end else begin
            if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) m_v[k] = 0;
            end else if (!mem_stall && pipe_adv) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_late[k] = m_late[k-1];
                end
                m_v[0]    = id_valid && id_rfwr && id_rd != 0 && !exp_stall;
                m_rd[0]   = id_rd;
                m_late[0] = id_late;
            end
`ifdef HAZARD_HILO_BUSY_EN
            if (!mem_stall) begin
                if (md_start) m_md = MD_LAT;
                else if (m_md > 0) m_md = m_md - 1;
            end
`endif
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic sample();
        @(negedge clk);
        model_eval();
        for (int i = 0; i < NREAD; i++)
            chk($sformatf("fwd_sel%0d", i), fwd_sel[i*SELW +: SELW], exp_sel[i]);
        chk("hazard_stall", hazard_stall, exp_stall);
        chk("md_busy", md_busy, (m_md != 0));
        chk("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic set_id(input bit v, input int s0, input int s1, input bit bj,
                          input bit wr, input int rd, input bit late);
        id_valid = v;
        id_src   = {AW'(s1), AW'(s0)};
        id_bj    = bj;
        id_rfwr  = wr;
        id_rd    = AW'(rd);
        id_late  = late;
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; mem_stall = 0; pipe_adv = 1; md_start = 0; id_md_use = 0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        advance();
        advance();
        rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        sample();
        chk("reset_stall", hazard_stall, 0);
        chk("reset_cnt", stall_cnt, 0);
        chk("reset_sel", fwd_sel, 0);
        advance();

        // lw $3 ; addu $4,$3,$5 -> two stall cycles then forward from entry 2
        set_id(1, 0, 0, 0, 1, 3, 1); tick();
        set_id(1, 3, 5, 0, 1, 4, 0);
        sample(); chk("t1_stall_a", hazard_stall, 1); advance();
        sample(); chk("t1_stall_b", hazard_stall, 1); advance();
        sample(); chk("t1_sel", fwd_sel[0 +: SELW], 3); chk("t1_free", hazard_stall, 0);
        chk("t1_cnt", stall_cnt, 2); advance();

        // addu $3 ; beq $3,$0 -> one stall then forward from entry 1
        do_reset();
        set_id(1, 0, 0, 0, 1, 3, 0); tick();
        set_id(1, 3, 0, 1, 0, 0, 0);
        sample(); chk("t2_bj_stall", hazard_stall, 1); advance();
        sample(); chk("t2_bj_sel", fwd_sel[0 +: SELW], 2); chk("t2_bj_free", hazard_stall, 0); advance();
        do_reset();
        set_id(1, 0, 0, 0, 1, 3, 0); tick();
        set_id(1, 3, 0, 0, 1, 4, 0);
        sample(); chk("t2_alu_sel", fwd_sel[0 +: SELW], 1); chk("t2_alu_free", hazard_stall, 0); advance();

        // writers of $7 at entries 0 and 2: youngest wins; $0 never forwards
        do_reset();
        set_id(1, 0, 0, 0, 1, 7, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 1, 7, 0); tick();
        set_id(1, 7, 0, 0, 1, 8, 0);
        sample(); chk("t3_young", fwd_sel[0 +: SELW], 1); chk("t3_zero", fwd_sel[SELW +: SELW], 0); advance();

        // flush during a load-use stall clears the tracker
        do_reset();
        set_id(1, 0, 0, 0, 1, 3, 1); tick();
        set_id(1, 3, 0, 0, 1, 4, 0);
        flush = 1;
        sample(); chk("t4_pre", hazard_stall, 1); advance();
        flush = 0;
        sample(); chk("t4_stall", hazard_stall, 0); chk("t4_sel", fwd_sel, 0); advance();

        // mem_stall freezes the tracker while the load-use stall persists
        do_reset();
        set_id(1, 0, 0, 0, 1, 3, 1); tick();
        set_id(1, 3, 0, 0, 1, 4, 0);
        mem_stall = 1;
        for (int c = 0; c < 5; c++) begin
            sample(); chk($sformatf("t5_hold%0d", c), hazard_stall, 1); advance();
        end
        mem_stall = 0;
        sample(); chk("t5_rel_a", hazard_stall, 1); advance();
        sample(); chk("t5_rel_b", hazard_stall, 1); advance();
        sample(); chk("t5_sel", fwd_sel[0 +: SELW], 3); chk("t5_cnt", stall_cnt, 7); advance();

        // reset asserted during a stall
        do_reset();
        set_id(1, 0, 0, 0, 1, 3, 1); tick();
        set_id(1, 3, 0, 0, 1, 4, 0);
        sample(); chk("t7_pre", hazard_stall, 1);
        rst = 1; advance(); rst = 0;
        sample(); chk("t7_stall", hazard_stall, 0); chk("t7_cnt", stall_cnt, 0); advance();

`ifdef HAZARD_HILO_BUSY_EN
        // md_start then mfhi: busy and stalled for MD_LAT cycles
        do_reset();
        md_start = 1; tick(); md_start = 0;
        set_id(1, 0, 0, 0, 1, 8, 0); id_md_use = 1;
        for (int c = 0; c < 4; c++) begin
            sample(); chk($sformatf("t6_busy%0d", c), md_busy, 1);
            chk($sformatf("t6_stall%0d", c), hazard_stall, 1); advance();
        end
        sample(); chk("t6_idle", md_busy, 0); chk("t6_free", hazard_stall, 0);
        chk("t6_cnt", stall_cnt, 4); advance();
        id_md_use = 0;
`endif

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(199) == 0);
            flush     = ($urandom_range(31) == 0);
            mem_stall = ($urandom_range(6) == 0);
            pipe_adv  = ($urandom_range(7) != 0);
            md_start  = ($urandom_range(19) == 0);
            id_md_use = ($urandom_range(3) == 0);
            set_id($urandom_range(7) != 0, $urandom_range(7), $urandom_range(7),
                   $urandom_range(4) == 0, $urandom_range(3) != 0,
                   $urandom_range(7), $urandom_range(2) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
